mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage load/store sequencer sitting directly upstream of DataMemory (256-byte, big-endian).
//  Accepts one load/store request per handshake from EX/MEM and drives DataMemory A/DI/Size/RW/E.
//  Delivers sign/zero-extended load data (or store completion) to MEM/WB over a valid/ready handshake.
//  Checks address range and alignment; faulting requests never reach the memory array.
// PARAMETERS
//  ADDR_W   8   DataMemory address width; in_addr[31:ADDR_W] must be zero
//  RD_W     5   destination register index width
// PORTS
//  clk            in   1   single clock, rising edge
//  reset          in   1   synchronous, active-high
//  in_valid       in   1   request present
//  in_ready       out  1   unit can accept request this cycle
//  in_store       in   1   1=store, 0=load
//  in_size        in   2   00 byte, 01 halfword, 10 word, 11 illegal
//  in_signed      in   1   load sign-extends when 1, zero-extends when 0
//  in_addr        in   32  byte address
//  in_wdata       in   32  store data (right-justified)
//  in_rd          in   RD_W  load destination register
//  mem_A          out  ADDR_W  to DataMemory A
//  mem_DI         out  32  to DataMemory DI
//  mem_Size       out  2   to DataMemory Size
//  mem_RW         out  1   to DataMemory RW (1=write)
//  mem_E          out  1   to DataMemory E
//  mem_DO         in   32  from DataMemory DO
//  out_valid      out  1   result present
//  out_ready      in   1   MEM/WB accepts result
//  out_data       out  32  extended load data; 0 for stores/faults
//  out_rd         out  RD_W  destination register
//  out_we         out  1   1 only for non-faulting load
//  out_fault      out  1   request faulted
//  out_fault_addr out  32  in_addr of faulting request; 0 otherwise
// BEHAVIOUR
//  Reset (sync, high): state=IDLE; in_ready=1 after reset deasserts; out_valid=0; out_* =0;
//   mem_E=0, mem_RW=0, mem_A=0, mem_DI=0, mem_Size=2'b10.
//  FSM states: IDLE, ACCESS, HOLD.
//   IDLE  : in_ready=1. in_valid -> latch request into req regs, evaluate fault -> ACCESS.
//   ACCESS: exactly one cycle. Non-fault: mem_* driven combinationally from req regs;
//           store: mem_RW=1, mem_E=1 (this cycle ONLY); load: mem_RW=0, mem_E=0, mem_DO
//           extended and registered at clock edge. Fault: mem_RW=0, mem_E=0. -> HOLD.
//   HOLD  : out_valid=1, outputs stable. out_ready=0 -> stay. out_ready=1: in_ready=1;
//           in_valid -> latch new req, ACCESS; else IDLE.
//  in_ready = (state==IDLE) | (state==HOLD & out_ready); zero in ACCESS.
//  Latency: accept edge N, memory access cycle N+1, out_valid from cycle N+2.
//   Peak throughput one request per 2 cycles.
//  Outside ACCESS, mem_E=0 and mem_RW=0 always (DataMemory writes on level; E must never glitch high).
//  Fault rules (evaluated at accept, priority order): size==11; in_addr[31:ADDR_W]!=0;
//   halfword with addr[0]!=0; word with addr[1:0]!=0. Fault -> out_fault=1, out_we=0, out_data=0.
//  Range: word access at 0xFC legal (touches FC..FF); no wrap-around possible after alignment check.
//  Load extension: byte  -> signed ? {{24{DO[7]}},DO[7:0]}  : {24'b0,DO[7:0]};
//                  half  -> signed ? {{16{DO[15]}},DO[15:0]} : {16'b0,DO[15:0]}; word -> DO.
//  Store: out_valid still asserted (completion token), out_we=0, out_data=0.
//  Reset in ACCESS: store already written combinationally in that cycle stays written;
//   result discarded, no out_valid. Reset in HOLD: pending result dropped.
// STRUCTURE
//  Shared package mem_pkg: SIZE_BYTE/SIZE_HALF/SIZE_WORD encodings, state enum
//   (IDLE/ACCESS/HOLD), fault cause constants.
//  Sub-module load_extend (combinational): DO + size + signed -> 32-bit result.
// TESTING
//  1 Store word 0xDEADBEEF @0x10 then load word @0x10 -> mem_E high exactly 1 cycle; out_data=0xDEADBEEF, out_we=1.
//  2 Store byte 0x80 @0x21; load byte signed @0x21 -> 0xFFFFFF80; unsigned -> 0x00000080.
//  3 Load half @0x03 -> out_fault=1, out_fault_addr=0x3, mem_E never 1; size 11 -> fault.
//  4 Store word @0x100 -> fault, Mem unchanged (readback @0x00 unchanged).
//  5 Back-to-back loads with out_ready=0 for 3 cycles -> out_* stable, in_ready=0; release -> next accepted same cycle.
//  6 Assert reset during ACCESS of load -> no out_valid, state IDLE, in_ready=1 next cycle.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store sequencer: access size encodings,
// FSM state type, fault causes and the accept-time fault classifier.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        FAULT_NONE  = 2'd0,
        FAULT_SIZE  = 2'd1,
        FAULT_RANGE = 2'd2,
        FAULT_ALIGN = 2'd3
    } fault_e;

    // Checks are in priority order; once aligned, no access can run past the top byte.
    function automatic fault_e classify_fault(input logic [1:0] size,
                                              input logic [31:0] addr,
                                              input int addr_w);
        fault_e cause;
        cause = FAULT_NONE;
        if (size == SIZE_ILLEGAL)
            cause = FAULT_SIZE;
        else if ((addr >> addr_w) != 32'd0)
            cause = FAULT_RANGE;
        else if ((size == SIZE_HALF) && addr[0])
            cause = FAULT_ALIGN;
        else if ((size == SIZE_WORD) && (addr[1:0] != 2'b00))
            cause = FAULT_ALIGN;
        return cause;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of right-justified DataMemory read data to a 32-bit result.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] do_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] data_o
);

    always_comb begin
        data_o = do_i;
        case (size_i)
            SIZE_BYTE: data_o = signed_i ? {{24{do_i[7]}}, do_i[7:0]}
                                         : {24'b0, do_i[7:0]};
            SIZE_HALF: data_o = signed_i ? {{16{do_i[15]}}, do_i[15:0]}
                                         : {16'b0, do_i[15:0]};
            default:   data_o = do_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer: accepts one request, performs a single-cycle
// DataMemory access, then holds the (possibly faulted) result until MEM/WB takes it.
module mem_access_unit #(
    parameter int ADDR_W = 8,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_store,
    input  logic [1:0]        in_size,
    input  logic              in_signed,
    input  logic [31:0]       in_addr,
    input  logic [31:0]       in_wdata,
    input  logic [RD_W-1:0]   in_rd,
    output logic [ADDR_W-1:0] mem_A,
    output logic [31:0]       mem_DI,
    output logic [1:0]        mem_Size,
    output logic              mem_RW,
    output logic              mem_E,
    input  logic [31:0]       mem_DO,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_we,
    output logic              out_fault,
    output logic [31:0]       out_fault_addr
);
    import mem_pkg::*;

    state_e            state_q, state_d;
    logic              accept;
    logic              mem_go;
    logic [31:0]       ext_data;

    logic              req_store_q;
    logic [1:0]        req_size_q;
    logic              req_signed_q;
    logic [31:0]       req_addr_q;
    logic [31:0]       req_wdata_q;
    logic [RD_W-1:0]   req_rd_q;
    fault_e            req_fault_q;

    logic [31:0]       out_data_q;
    logic [RD_W-1:0]   out_rd_q;
    logic              out_we_q;
    logic              out_fault_q;
    logic [31:0]       out_fault_addr_q;

    assign accept = in_valid && in_ready;
    assign mem_go = (state_q == ACCESS) && (req_fault_q == FAULT_NONE);

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = ACCESS;
            ACCESS:  state_d = HOLD;
            HOLD:    if (out_ready) state_d = in_valid ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory strobes are decoded straight from state so E can only rise during ACCESS.
    always_comb begin
        in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
        out_valid = (state_q == HOLD);
        mem_A     = '0;
        mem_DI    = 32'd0;
        mem_Size  = SIZE_WORD;
        mem_RW    = 1'b0;
        mem_E     = 1'b0;
        if (mem_go) begin
            mem_A    = req_addr_q[ADDR_W-1:0];
            mem_DI   = req_wdata_q;
            mem_Size = req_size_q;
            mem_RW   = req_store_q;
            mem_E    = req_store_q;
        end
    end

    load_extend u_load_extend (
        .do_i     (mem_DO),
        .size_i   (req_size_q),
        .signed_i (req_signed_q),
        .data_o   (ext_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            req_store_q      <= 1'b0;
            req_size_q       <= SIZE_WORD;
            req_signed_q     <= 1'b0;
            req_addr_q       <= 32'd0;
            req_wdata_q      <= 32'd0;
            req_rd_q         <= '0;
            req_fault_q      <= FAULT_NONE;
            out_data_q       <= 32'd0;
            out_rd_q         <= '0;
            out_we_q         <= 1'b0;
            out_fault_q      <= 1'b0;
            out_fault_addr_q <= 32'd0;
        end else begin
            if (accept) begin
                req_store_q  <= in_store;
                req_size_q   <= in_size;
                req_signed_q <= in_signed;
                req_addr_q   <= in_addr;
                req_wdata_q  <= in_wdata;
                req_rd_q     <= in_rd;
                req_fault_q  <= classify_fault(in_size, in_addr, ADDR_W);
            end
            if (state_q == ACCESS) begin
                out_rd_q <= req_rd_q;
                if (req_fault_q != FAULT_NONE) begin
                    out_data_q       <= 32'd0;
                    out_we_q         <= 1'b0;
                    out_fault_q      <= 1'b1;
                    out_fault_addr_q <= req_addr_q;
                end else begin
                    out_data_q       <= req_store_q ? 32'd0 : ext_data;
                    out_we_q         <= !req_store_q;
                    out_fault_q      <= 1'b0;
                    out_fault_addr_q <= 32'd0;
                end
            end
        end
    end

    assign out_data       = out_data_q;
    assign out_rd         = out_rd_q;
    assign out_we         = out_we_q;
    assign out_fault      = out_fault_q;
    assign out_fault_addr = out_fault_addr_q;

endmodule
